// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter: FSM states, transfer sizes and
// byte-lane helpers used for little-endian packing.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    STORE = 2'd3
  } state_t;

  localparam logic [2:0] SZ_B = 3'd1;
  localparam logic [2:0] SZ_H = 3'd2;
  localparam logic [2:0] SZ_W = 3'd4;

  // Any size code other than byte or halfword is a word transfer.
  function automatic logic [2:0] norm_size(input logic [2:0] size);
    case (size)
      SZ_B:    return SZ_B;
      SZ_H:    return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [2:0] lane);
    return 8'(word >> {lane, 3'b000});
  endfunction

  function automatic logic [31:0] put_lane(input logic [31:0] word, input logic [2:0] lane,
                                           input logic [7:0] b);
    return (word & ~(32'h0000_00FF << {lane, 3'b000})) | (32'(b) << {lane, 3'b000});
  endfunction

endpackage

// File: rtl/mem_byte_seq.sv
// Byte sequencer: latches the transfer base and length, counts cycles in the
// transfer and produces the next byte address plus end-of-transfer flags.
module mem_byte_seq
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        start,
  input  logic        step,
  input  logic [31:0] base_in,
  input  logic [2:0]  n_in,
  output logic [2:0]  cnt,
  output logic [31:0] next_addr,
  output logic        last_addr,
  output logic        last_cap
);

  logic [31:0] base;
  logic [2:0]  n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base <= '0;
      n    <= '0;
      cnt  <= '0;
    end else if (rdy) begin
      if (start) begin
        base <= base_in;
        n    <= n_in;
        cnt  <= '0;
      end else if (step) begin
        cnt <= cnt + 3'd1;
      end
    end
  end

  // cnt is the index of the byte whose address is on the bus this cycle;
  // read data trails the address by one cycle, so capture ends at cnt == n.
  always_comb begin
    next_addr = base + 32'(cnt) + 32'd1;
    last_addr = (4'(cnt) + 4'd1) >= 4'(n);
    last_cap  = (cnt == n);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing a byte-wide synchronous RAM between instruction fetch and a
// data port. Optional fetch anti-starvation ageing under `MEM_ARB_AGE_EN.
module mem_arbiter
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_data,
  output logic        if_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  input  logic        flush,
  output logic [31:0] ram_a,
  output logic [7:0]  ram_dout,
  output logic        ram_wr,
  input  logic [7:0]  ram_din
);

  state_t      state;
  logic [31:0] wdata_q;
  logic [31:0] rbuf;
  logic        ram_wr_q;

  logic        idle_free, fetch_ok, grant_d, grant_f, start;
  logic [2:0]  cnt, cap_lane, nxt_lane;
  logic [31:0] next_addr, cap_word;
  logic        last_addr, last_cap;

`ifdef MEM_ARB_AGE_EN
  logic [1:0] age;
`endif

  always_comb begin
    // The done cycle is spent in IDLE but must not grant (one-cycle bubble).
    idle_free = (state == IDLE) && !if_done && !d_done;
    fetch_ok  = if_req && !flush;
`ifdef MEM_ARB_AGE_EN
    grant_d   = idle_free && d_req && !((age == 2'd3) && fetch_ok);
`else
    grant_d   = idle_free && d_req;
`endif
    grant_f   = idle_free && fetch_ok && !grant_d;
    start     = grant_d || grant_f;
    cap_lane  = cnt - 3'd1;
    nxt_lane  = cnt + 3'd1;
    cap_word  = put_lane(rbuf, cap_lane, ram_din);
  end

  mem_byte_seq u_seq (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .start     (start),
    .step      (state != IDLE),
    .base_in   (grant_d ? d_addr : if_addr),
    .n_in      (grant_d ? norm_size(d_size) : SZ_W),
    .cnt       (cnt),
    .next_addr (next_addr),
    .last_addr (last_addr),
    .last_cap  (last_cap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wdata_q  <= '0;
      rbuf     <= '0;
      if_data  <= '0;
      d_rdata  <= '0;
      if_done  <= 1'b0;
      d_done   <= 1'b0;
      ram_a    <= '0;
      ram_dout <= '0;
      ram_wr_q <= 1'b0;
    end else if (rdy) begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            ram_a   <= d_addr;
            wdata_q <= d_wdata;
            rbuf    <= '0;
            if (d_we) begin
              state    <= STORE;
              ram_wr_q <= 1'b1;
              ram_dout <= byte_lane(d_wdata, 3'd0);
            end else begin
              state <= LOAD;
            end
          end else if (grant_f) begin
            state <= FETCH;
            ram_a <= if_addr;
            rbuf  <= '0;
          end
        end
        FETCH, LOAD: begin
          if (state == FETCH && flush) begin
            state <= IDLE;
            ram_a <= '0;
          end else begin
            if (cnt != 3'd0) rbuf <= cap_word;
            if (last_cap) begin
              state <= IDLE;
              ram_a <= '0;
              if (state == FETCH) begin
                if_data <= cap_word;
                if_done <= 1'b1;
              end else begin
                d_rdata <= cap_word;
                d_done  <= 1'b1;
              end
            end else if (!last_addr) begin
              ram_a <= next_addr;
            end
          end
        end
        STORE: begin
          if (last_addr) begin
            state    <= IDLE;
            d_done   <= 1'b1;
            ram_wr_q <= 1'b0;
            ram_dout <= '0;
            ram_a    <= '0;
          end else begin
            ram_a    <= next_addr;
            ram_dout <= byte_lane(wdata_q, nxt_lane);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_AGE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age <= '0;
    end else if (rdy) begin
      if (!if_req || grant_f) age <= '0;
      else if (grant_d && age != 2'd3) age <= age + 2'd1;
    end
  end
`endif

  assign ram_wr = ram_wr_q && rdy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level reference model with
// a byte-array memory image, directed scenarios and randomized transfers.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, if_req, d_req, d_we, flush, if_done, d_done, ram_wr;
  logic [31:0] if_addr, if_data, d_addr, d_wdata, d_rdata, ram_a;
  logic [2:0]  d_size;
  logic [7:0]  ram_dout, ram_din;

  logic [7:0]  mem     [0:1023];
  logic [7:0]  exp_mem [0:1023];
  int unsigned wr_count, bad_wr;
  int          n_checks = 0, n_fail = 0;
  logic [31:0] exp_if_data, exp_d_rdata;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .flush(flush),
    .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din)
  );

  function automatic logic [7:0] init_byte(input int a);
    if (a >= 256 && a <= 259) return 8'((a - 255) * 17);
    return 8'((a * 73) ^ (a >> 3) ^ 8'h5A);
  endfunction

  // Byte-wide synchronous RAM.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = init_byte(i);
    wr_count = 0;
    bad_wr   = 0;
    forever begin
      @(posedge clk);
      ram_din <= mem[ram_a[9:0]];
      if (ram_wr) begin
        mem[ram_a[9:0]] = ram_dout;
        wr_count++;
        if (!rdy) bad_wr++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr, input int n);
    logic [31:0] w = '0;
    for (int i = 0; i < n; i++) w |= 32'(exp_mem[int'(addr[9:0]) + i]) << (8 * i);
    return w;
  endfunction

  function automatic int size_bytes(input logic [2:0] sz);
    return (sz == 3'd1) ? 1 : (sz == 3'd2) ? 2 : 4;
  endfunction

  // One transfer started in an idle-free cycle t. flush_k>0 flushes a fetch in
  // cycle t+flush_k; idle_flush blocks the fetch in cycle t; stall_len>0 drops
  // rdy from cycle t+stall_k.
  task automatic xact(input bit is_f, input bit we, input logic [31:0] addr,
                      input logic [2:0] sz, input logic [31:0] wd, input int flush_k,
                      input bit idle_flush, input int stall_k, input int stall_len);
    int n, exp_c, lim, c, got_c;
    logic [31:0] got_data, exp_word;
    int unsigned wr0;
    n = is_f ? 4 : size_bytes(sz);
    exp_word = mem_word(addr, n);
    if (flush_k > 0) exp_c = -1;
    else if (!is_f && we) exp_c = n + 1 + stall_len;
    else exp_c = n + 2 + int'(idle_flush);
    lim = (exp_c < 0) ? 8 : exp_c + 3;
    wr0 = wr_count;
    got_data = '0;
    if (is_f) begin
      if_req = 1'b1; if_addr = addr; flush = idle_flush;
    end else begin
      d_req = 1'b1; d_we = we; d_size = sz; d_addr = addr; d_wdata = wd;
    end
    c = 0;
    got_c = -1;
    while (c <= lim && got_c < 0) begin
      @(negedge clk);
      if (is_f ? if_done : d_done) begin
        got_c = c;
        got_data = is_f ? if_data : d_rdata;
        check("done_ram_a_idle", ram_a, 32'h0);
        if_req = 1'b0;
        d_req  = 1'b0;
      end else if (flush_k > 0 && c == flush_k + 1) begin
        check("flush_ram_a_idle", ram_a, 32'h0);
      end
      if (got_c < 0) begin
        next_cycle();
        c++;
        rdy   = !(stall_len > 0 && c >= stall_k && c < stall_k + stall_len);
        flush = (flush_k > 0 && c == flush_k);
        if (flush) if_req = 1'b0;
      end
    end
    rdy = 1'b1; flush = 1'b0; if_req = 1'b0; d_req = 1'b0;
    check(is_f ? "fetch_done_cycle" : we ? "store_done_cycle" : "load_done_cycle",
          32'(got_c), 32'(exp_c));
    if (is_f && exp_c >= 0) begin
      check("fetch_data", got_data, exp_word);
      exp_if_data = exp_word;
      check("d_rdata_hold", d_rdata, exp_d_rdata);
    end else if (!is_f && !we) begin
      check("load_data", got_data, exp_word);
      exp_d_rdata = exp_word;
      check("if_data_hold", if_data, exp_if_data);
    end else if (!is_f) begin
      for (int i = 0; i < n; i++) exp_mem[int'(addr[9:0]) + i] = 8'(wd >> (8 * i));
      check("store_write_count", 32'(wr_count - wr0), 32'(n));
      for (int i = -1; i < 5; i++)
        check("store_mem", 32'(mem[int'(addr[9:0]) + i]), 32'(exp_mem[int'(addr[9:0]) + i]));
      check("d_rdata_hold", d_rdata, exp_d_rdata);
    end
    if (is_f && exp_c < 0) check("flush_no_write", 32'(wr_count - wr0), 32'h0);
    next_cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, gd, gf, k;
    logic [31:0] dval, fval;
    bit seq [8];
    for (int i = 0; i < 1024; i++) exp_mem[i] = init_byte(i);
    rst = 1'b1; rdy = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; flush = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_size = '0;
    exp_if_data = '0; exp_d_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_if_done", 32'(if_done), 32'h0);
    check("rst_d_done", 32'(d_done), 32'h0);
    check("rst_if_data", if_data, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check("rst_ram_a", ram_a, 32'h0);
    check("rst_ram_dout", 32'(ram_dout), 32'h0);
    check("rst_ram_wr", 32'(ram_wr), 32'h0);
    next_cycle();
    rst = 1'b0;

    // Word load, halfword store, word store stalled after byte 1.
    xact(0, 0, 32'h100, 3'd4, '0, 0, 0, 0, 0);
    check("load_0x100_value", d_rdata, 32'h4433_2211);
    xact(0, 1, 32'h200, 3'd2, 32'hAABB_CCDD, 0, 0, 0, 0);
    check("store_0x202_untouched", 32'(mem[10'h202]), 32'(init_byte(32'h202)));
    xact(0, 1, 32'h210, 3'd4, 32'h1234_5678, 0, 0, 3, 3);

    // Simultaneous requests: data first, fetch right after the bubble.
    d_req = 1'b1; d_we = 1'b0; d_size = 3'd1; d_addr = 32'h10;
    if_req = 1'b1; if_addr = 32'h0;
    c = 0; gd = -1; gf = -1; dval = '0; fval = '0;
    while (c <= 20 && gf < 0) begin
      @(negedge clk);
      if (d_done && gd < 0) begin gd = c; dval = d_rdata; d_req = 1'b0; end
      if (if_done) begin gf = c; fval = if_data; if_req = 1'b0; end
      if (gf < 0) begin next_cycle(); c++; end
    end
    if_req = 1'b0; d_req = 1'b0;
    check("prio_d_done_cycle", 32'(gd), 32'd3);
    check("prio_d_data", dval, mem_word(32'h10, 1));
    check("prio_if_done_cycle", 32'(gf), 32'd10);
    check("prio_if_data", fval, mem_word(32'h0, 4));
    exp_d_rdata = mem_word(32'h10, 1);
    exp_if_data = mem_word(32'h0, 4);
    next_cycle();

    // Fetch squashed by flush, then a clean fetch; flush while idle delays grant.
    xact(1, 0, 32'h40, 3'd4, '0, 3, 0, 0, 0);
    xact(1, 0, 32'h80, 3'd4, '0, 0, 0, 0, 0);
    xact(1, 0, 32'h300, 3'd4, '0, 0, 1, 0, 0);

    // Both requesters held continuously: grant order observed from done pulses.
    d_req = 1'b1; d_we = 1'b0; d_size = 3'd1; d_addr = 32'h20;
    if_req = 1'b1; if_addr = 32'h24;
    k = 0; c = 0;
    while (k < 8 && c < 200) begin
      @(negedge clk);
      if (d_done) begin seq[k] = 1'b0; k++; end
      else if (if_done) begin seq[k] = 1'b1; k++; end
      next_cycle();
      c++;
    end
    d_req = 1'b0; if_req = 1'b0;
    check("age_grant_count", 32'(k), 32'd8);
    for (int i = 0; i < 8; i++) begin
`ifdef MEM_ARB_AGE_EN
      check("age_grant_seq", 32'(seq[i]), 32'((i % 4) == 3));
`else
      check("age_grant_seq", 32'(seq[i]), 32'h0);
`endif
    end
    exp_d_rdata = mem_word(32'h20, 1);
`ifdef MEM_ARB_AGE_EN
    exp_if_data = mem_word(32'h24, 4);
`endif
    repeat (2) next_cycle();

    // Reset in the middle of a load with rdy low; grant right after release.
    d_req = 1'b1; d_we = 1'b0; d_size = 3'd4; d_addr = 32'h180;
    repeat (3) next_cycle();
    rdy = 1'b0; rst = 1'b1; d_req = 1'b0;
    @(negedge clk);
    check("rst_mid_d_done", 32'(d_done), 32'h0);
    check("rst_mid_d_rdata", d_rdata, 32'h0);
    check("rst_mid_if_data", if_data, 32'h0);
    check("rst_mid_ram_a", ram_a, 32'h0);
    next_cycle();
    rst = 1'b0; rdy = 1'b1;
    exp_d_rdata = '0; exp_if_data = '0;
    xact(0, 0, 32'h184, 3'd4, '0, 0, 0, 0, 0);

    // Randomized transfers against the memory image.
    for (int unsigned it = 0; it < 80; it++) begin
      int kind, fk, sk, sl;
      bit idf;
      logic [31:0] a, wd;
      logic [2:0] sz;
      kind = int'($urandom_range(0, 2));
      a    = 32'($urandom_range(4, 1015));
      sz   = 3'($urandom_range(0, 7));
      wd   = $urandom;
      fk = 0; idf = 1'b0; sk = 0; sl = 0;
      if (kind == 0) begin
        if ($urandom_range(0, 3) == 0) fk = int'($urandom_range(1, 5));
        else if ($urandom_range(0, 5) == 0) idf = 1'b1;
        xact(1, 0, a, 3'd4, '0, fk, idf, 0, 0);
      end else if (kind == 1) begin
        xact(0, 0, a, sz, '0, 0, 0, 0, 0);
      end else begin
        if ($urandom_range(0, 2) == 0) begin
          sk = int'($urandom_range(1, size_bytes(sz)));
          sl = int'($urandom_range(1, 3));
        end
        xact(0, 1, a, sz, wd, 0, 0, sk, sl);
      end
      repeat ($urandom_range(0, 2)) next_cycle();
    end

    check("no_write_while_rdy_low", 32'(bad_wr), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have: clk input 1 clock; rst input 1 reset, asynchronous, active-high; rdy input 1 global enable, all state frozen when low.
REQ-002 SHALL have the instruction-fetch port: if_req input 1, level request; if_addr input 32; if_data output 32; if_done output 1, one-cycle pulse.
REQ-003 SHALL have the data port: d_req input 1; d_we input 1 (1=store); d_size input 3 (bytes: 1, 2 or 4); d_addr input 32; d_wdata input 32; d_rdata output 32; d_done output 1, one-cycle pulse.
REQ-004 SHALL have flush input 1, which squashes the fetch in flight.
REQ-005 SHALL have the RAM port: ram_a output 32; ram_dout output 8; ram_wr output 1; ram_din input 8. Synchronous read: data for the address presented in cycle k appears on ram_din in cycle k+1.

Function
REQ-006 SHALL implement FSM states IDLE, FETCH, LOAD, STORE; reset state IDLE.
REQ-007 SHALL grant only in IDLE. Grant cycle t moves to FETCH, LOAD or STORE at the t edge and latches the address, size and wdata.
REQ-008 SHALL give data priority over fetch on a simultaneous request (default policy).
REQ-009 SHALL drive bytes little-endian: byte i at base+i, i=0..N-1. Byte i address is registered and valid in cycle t+1+i.
REQ-010 LOAD/FETCH SHALL capture ram_din into result byte i at the end of cycle t+2+i. done SHALL pulse in cycle t+N+2 with the result valid in that cycle. Result is zero-extended above N bytes.
REQ-011 FETCH SHALL always use N=4, so if_done is in cycle t+6.
REQ-012 STORE SHALL assert ram_wr with ram_dout=d_wdata byte i in cycles t+1..t+N, and pulse d_done in cycle t+N+1.
REQ-013 SHALL treat any d_size other than 1 or 2 as 4.
REQ-014 SHALL return to IDLE in the done cycle and grant nothing during it, giving one bubble. Requesters drop req in their done cycle.
REQ-015 flush during FETCH SHALL abort at that edge, suppress if_done and return to IDLE. flush in IDLE SHALL block an if_req grant that cycle.
REQ-016 flush SHALL NOT affect LOAD or STORE.
REQ-017 While rdy=0, SHALL hold every register and force ram_wr=0. A pending store byte is written in the next rdy=1 cycle.
REQ-018 Outside STORE, ram_wr SHALL be 0 and ram_dout SHALL be 0. ram_a SHALL be 0 in IDLE.
REQ-019 if_data and d_rdata SHALL hold their last values until the next done pulse on the same port.

Reset
REQ-020 rst SHALL force the following regardless of rdy: state=IDLE, byte counter=0, if_done=0, d_done=0, if_data=0, d_rdata=0, ram_a=0, ram_dout=0, ram_wr=0, age counter=0.
REQ-021 A transfer interrupted by rst SHALL be discarded with no done pulse. The first grant SHALL be possible in the first cycle after rst falls.

Configuration
REQ-022 Macro MEM_ARB_AGE_EN defined: a 2-bit age counter counts consecutive data grants made while if_req is pending. On reaching 3, the next grant goes to fetch even if d_req is set. The counter clears on any fetch grant or when if_req is low.
REQ-023 MEM_ARB_AGE_EN undefined: strict data priority per REQ-008; no age counter is instantiated.

Structure
REQ-024 Shared package mem_pkg SHALL hold the FSM state encoding, size constants (SZ_B=1, SZ_H=2, SZ_W=4) and the byte-lane helper.
REQ-025 Sub-module mem_byte_seq SHALL hold the byte counter, address generation (base+i) and last-byte detection. The FSM and arbitration stay in mem_arbiter.

Verification
REQ-026 Load: d_req, d_we=0, d_size=4, d_addr=0x100, RAM 0x100..0x103 = 11,22,33,44 -> d_rdata=0x44332211, d_done exactly at t+6.
REQ-027 Store: d_we=1, d_size=2, d_addr=0x200, d_wdata=0xAABBCCDD -> ram_wr in 2 cycles, 0x200=DD, 0x201=CC, d_done at t+3, 0x202 untouched.
REQ-028 Simultaneous if_req (0x0) and load d_size=1 (0x10) -> load granted first. Fetch granted in the cycle after d_done; if_done 6 cycles later.
REQ-029 Fetch from 0x40 with flush in cycle t+3 -> no if_done, IDLE at t+4. A new fetch from 0x80 returns RAM 0x80..0x83.
REQ-030 Store d_size=4 with rdy low for 3 cycles after byte 1 -> no writes while low. All 4 bytes written exactly once; d_done delayed by 3 cycles.
REQ-031 With MEM_ARB_AGE_EN, d_req and if_req held continuously -> grant sequence D,D,D,F,D,D,D,F. Without the macro, fetch is never granted while d_req is set.
